// File: rtl/ap_ctrl_txn_sequencer.sv
// Upstream driver for an ap_ctrl_hs HLS block.
// Issues NUM_TXN transactions per run, measures the latency of each one
// (the first ap_start cycle counts as 1), and raises a run-level finish flag.
module ap_ctrl_txn_sequencer #(
  parameter int NUM_TXN = 4,
  parameter int TXN_W   = 16,
  parameter int CNT_W   = 32,
  parameter int GAP_CYC = 0,
  parameter int TIMEOUT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_go,
  output logic             o_dut_ap_start,
  input  logic             i_dut_ap_ready,
  input  logic             i_dut_ap_done,
  output logic             o_busy,
  output logic [TXN_W-1:0] o_txn_issued,
  output logic [TXN_W-1:0] o_txn_done,
  output logic             o_lat_valid,
  output logic [CNT_W-1:0] o_last_latency,
  output logic [CNT_W-1:0] o_max_latency,
  output logic             o_finish,
  output logic             o_error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAT_MAX  = '1;
  localparam logic [TXN_W-1:0] TXN_NUM  = TXN_W'(NUM_TXN);
  localparam logic [TXN_W-1:0] TXN_LAST = TXN_W'(NUM_TXN - 1);
  localparam logic [31:0]      GAP_LAST = 32'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [31:0]      r_gap_cnt;
  logic [TXN_W-1:0] r_txn_issued;
  logic [TXN_W-1:0] r_txn_done;
  logic [CNT_W-1:0] r_last_latency;
  logic [CNT_W-1:0] r_max_latency;
  logic             r_lat_valid;
  logic             r_error;

  logic w_active;
  logic w_go_accept;
  logic w_done_evt;
  logic w_last_txn;
  logic w_timeout;
  logic w_stray_done;
  logic w_gap_end;
  logic w_restart;

  // Event decode shared by the FSM and the datapath
  assign w_active     = (r_state == S_START) || (r_state == S_WAIT_DONE);
  assign w_go_accept  = i_go && ((r_state == S_IDLE) || (r_state == S_FINISH));
  // Done in START only completes the transaction together with ready
  assign w_done_evt   = ((r_state == S_START) && i_dut_ap_ready && i_dut_ap_done) ||
                        ((r_state == S_WAIT_DONE) && i_dut_ap_done);
  assign w_last_txn   = w_done_evt && (r_txn_done == TXN_LAST);
  assign w_timeout    = (TIMEOUT != 0) && w_active && !w_done_evt && (r_lat_cnt == TO_LIM);
  assign w_stray_done = i_dut_ap_done &&
                        ((r_state == S_IDLE) || (r_state == S_GAP) || (r_state == S_FINISH));
  assign w_gap_end    = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);
  // Any entry into START begins a fresh latency count at 1
  assign w_restart    = w_go_accept || w_gap_end || (w_done_evt && (w_state_next == S_START));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_go_accept) w_state_next = S_START;
      S_START, S_WAIT_DONE: begin
        if (w_timeout)
          w_state_next = S_FINISH;
        else if (w_done_evt)
          w_state_next = w_last_txn ? S_FINISH : ((GAP_CYC > 0) ? S_GAP : S_START);
        else if ((r_state == S_START) && i_dut_ap_ready)
          w_state_next = S_WAIT_DONE;
      end
      S_GAP:    if (w_gap_end) w_state_next = S_START;
      S_FINISH: if (w_go_accept) w_state_next = S_START;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state only
  always_comb begin
    o_dut_ap_start = (r_state == S_START);
    o_busy         = (r_state == S_START) || (r_state == S_WAIT_DONE) || (r_state == S_GAP);
    o_finish       = (r_state == S_FINISH);
  end

  // Latency and gap counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lat_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_restart)
        r_lat_cnt <= CNT_W'(1);
      else if (w_active && (r_lat_cnt != LAT_MAX))
        r_lat_cnt <= r_lat_cnt + CNT_W'(1);
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 32'd1;
      else                  r_gap_cnt <= '0;
    end
  end

  // Run counters, latency results and sticky error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_txn_issued   <= '0;
      r_txn_done     <= '0;
      r_last_latency <= '0;
      r_max_latency  <= '0;
      r_lat_valid    <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_lat_valid <= w_done_evt;
      if (w_go_accept) begin
        r_txn_issued  <= '0;
        r_txn_done    <= '0;
        r_max_latency <= '0;
      end else begin
        if ((r_state == S_START) && i_dut_ap_ready && (r_txn_issued != TXN_NUM))
          r_txn_issued <= r_txn_issued + TXN_W'(1);
        if (w_done_evt && (r_txn_done != TXN_NUM))
          r_txn_done <= r_txn_done + TXN_W'(1);
        if (w_done_evt && (r_lat_cnt > r_max_latency))
          r_max_latency <= r_lat_cnt;
      end
      if (w_done_evt)
        r_last_latency <= r_lat_cnt;
      // A stray done wins over the clear that go performs
      if (w_go_accept)
        r_error <= w_stray_done;
      else if (w_stray_done || w_timeout)
        r_error <= 1'b1;
    end
  end

  assign o_txn_issued   = r_txn_issued;
  assign o_txn_done     = r_txn_done;
  assign o_lat_valid    = r_lat_valid;
  assign o_last_latency = r_last_latency;
  assign o_max_latency  = r_max_latency;
  assign o_error        = r_error;

endmodule

// File: tb/tb_ap_ctrl_txn_sequencer.sv
// Bench for ap_ctrl_txn_sequencer: three instances (plain, gapped, timeout)
// driven by directed cycle vectors and hand-written multi-cycle sequences.
module tb_ap_ctrl_txn_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        go    [3];
  logic        rdy   [3];
  logic        dn    [3];
  logic        st    [3];
  logic        bz    [3];
  logic        lv    [3];
  logic        fn    [3];
  logic        er    [3];
  logic [15:0] iss   [3];
  logic [15:0] td    [3];
  logic [31:0] ll    [3];
  logic [31:0] mx    [3];

  // Instance 0: NUM_TXN=4, no gap, no timeout
  ap_ctrl_txn_sequencer #(.NUM_TXN(4), .TXN_W(16), .CNT_W(32), .GAP_CYC(0), .TIMEOUT(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_go(go[0]), .o_dut_ap_start(st[0]),
    .i_dut_ap_ready(rdy[0]), .i_dut_ap_done(dn[0]), .o_busy(bz[0]),
    .o_txn_issued(iss[0]), .o_txn_done(td[0]), .o_lat_valid(lv[0]),
    .o_last_latency(ll[0]), .o_max_latency(mx[0]), .o_finish(fn[0]), .o_error(er[0]));

  // Instance 1: three idle cycles between transactions
  ap_ctrl_txn_sequencer #(.NUM_TXN(4), .TXN_W(16), .CNT_W(32), .GAP_CYC(3), .TIMEOUT(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_go(go[1]), .o_dut_ap_start(st[1]),
    .i_dut_ap_ready(rdy[1]), .i_dut_ap_done(dn[1]), .o_busy(bz[1]),
    .o_txn_issued(iss[1]), .o_txn_done(td[1]), .o_lat_valid(lv[1]),
    .o_last_latency(ll[1]), .o_max_latency(mx[1]), .o_finish(fn[1]), .o_error(er[1]));

  // Instance 2: 10-cycle transaction timeout
  ap_ctrl_txn_sequencer #(.NUM_TXN(4), .TXN_W(16), .CNT_W(32), .GAP_CYC(0), .TIMEOUT(10)) u_c (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_go(go[2]), .o_dut_ap_start(st[2]),
    .i_dut_ap_ready(rdy[2]), .i_dut_ap_done(dn[2]), .o_busy(bz[2]),
    .o_txn_issued(iss[2]), .o_txn_done(td[2]), .o_lat_valid(lv[2]),
    .o_last_latency(ll[2]), .o_max_latency(mx[2]), .o_finish(fn[2]), .o_error(er[2]));

  int n_checks = 0;
  int n_errors = 0;
  int lv_total_a = 0;

  // Running count of lat_valid pulses on instance 0
  always @(posedge clk) if (lv[0]) lv_total_a <= lv_total_a + 1;

  typedef struct {
    logic go, rdy, done;
    logic st, bz, fn, lv;
    int   ll, mx, iss, td;
    logic er;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv_base;
    int lows;

    //           go rdy dn  st bz fn lv  ll mx iss td  er
    tbl[0]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 0,0,0,0, 1'b0}; // stray done in IDLE
    tbl[1]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0,0,0,0, 1'b1}; // error seen, go
    tbl[2]  = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0, 0,0,0,0, 1'b0}; // combinational DUT
    tbl[3]  = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 1,1,1,1, 1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 1,1,2,2, 1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 1,1,3,3, 1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1, 1,1,4,4, 1'b0}; // finish after 4th done
    tbl[7]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 1,1,4,4, 1'b0}; // go from FINISH
    tbl[8]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, 1,0,0,0, 1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0, 1,0,0,0, 1'b0};
    tbl[10] = '{1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 1,0,1,0, 1'b0}; // ready held, ignored
    tbl[11] = '{1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0, 1,0,1,0, 1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1, 4,4,1,1, 1'b0};
    tbl[13] = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0, 4,4,1,1, 1'b0};

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; go[i] = 1'b0; rdy[i] = 1'b0; dn[i] = 1'b0;
    end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_start",   32'(st[i]),  32'd0);
      chk("reset_busy",    32'(bz[i]),  32'd0);
      chk("reset_issued",  32'(iss[i]), 32'd0);
      chk("reset_lastlat", ll[i],       32'd0);
    end
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Table-driven cycle vectors on instance 0
    for (int i = 0; i < NVEC; i++) begin
      chk($sformatf("vec%0d_start", i),  32'(st[0]),  32'(tbl[i].st));
      chk($sformatf("vec%0d_busy", i),   32'(bz[0]),  32'(tbl[i].bz));
      chk($sformatf("vec%0d_finish", i), 32'(fn[0]),  32'(tbl[i].fn));
      chk($sformatf("vec%0d_latv", i),   32'(lv[0]),  32'(tbl[i].lv));
      chk($sformatf("vec%0d_lastlat", i), ll[0],      32'(tbl[i].ll));
      chk($sformatf("vec%0d_maxlat", i), mx[0],       32'(tbl[i].mx));
      chk($sformatf("vec%0d_issued", i), 32'(iss[0]), 32'(tbl[i].iss));
      chk($sformatf("vec%0d_done", i),   32'(td[0]),  32'(tbl[i].td));
      chk($sformatf("vec%0d_error", i),  32'(er[0]),  32'(tbl[i].er));
      $display("vec %0d: start=%0d busy=%0d issued=%0d done=%0d lastlat=%0d",
               i, st[0], bz[0], iss[0], td[0], ll[0]);
      go[0] = tbl[i].go; rdy[0] = tbl[i].rdy; dn[0] = tbl[i].done;
      tick();
    end
    go[0] = 1'b0; rdy[0] = 1'b0; dn[0] = 1'b0;

    // Reset in WAIT_DONE of the 2nd transaction
    chk("mid_start_low", 32'(st[0]),  32'd0);
    chk("mid_issued",    32'(iss[0]), 32'd2);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("rst_start",  32'(st[0]),  32'd0);
    chk("rst_busy",   32'(bz[0]),  32'd0);
    chk("rst_issued", 32'(iss[0]), 32'd0);
    chk("rst_done",   32'(td[0]),  32'd0);
    chk("rst_maxlat", mx[0],       32'd0);
    chk("rst_lastlat", ll[0],      32'd0);
    tick();
    rst_n[0] = 1'b1;

    // Fresh basic run: ready on the start cycle, done 5 cycles later
    go[0] = 1'b1;
    tick();
    go[0] = 1'b0;
    chk("fresh_issued", 32'(iss[0]), 32'd0);
    lv_base = lv_total_a;
    for (int t = 0; t < 4; t++) begin
      chk("basic_start", 32'(st[0]), 32'd1);
      rdy[0] = 1'b1;
      tick();
      rdy[0] = 1'b0;
      chk("basic_issued", 32'(iss[0]), 32'(t + 1));
      repeat (4) tick();
      dn[0] = 1'b1;
      tick();
      dn[0] = 1'b0;
      chk("basic_latv", 32'(lv[0]), 32'd1);
      chk("basic_lat",  ll[0],      32'd6);
      $display("basic txn %0d: latency %0d", t, ll[0]);
    end
    tick();
    chk("basic_finish", 32'(fn[0]), 32'd1);
    chk("basic_busy",   32'(bz[0]), 32'd0);
    chk("basic_start_low", 32'(st[0]), 32'd0);
    chk("basic_done",   32'(td[0]), 32'd4);
    chk("basic_maxlat", mx[0],      32'd6);
    chk("basic_pulses", 32'(lv_total_a - lv_base), 32'd4);

    // Gap and backpressure on instance 1
    go[1] = 1'b1;
    tick();
    go[1] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk("gap_start", 32'(st[1]), 32'd1);
      repeat (2) tick();
      rdy[1] = 1'b1;
      tick();
      rdy[1] = 1'b0;
      chk("gap_wait_start_low", 32'(st[1]), 32'd0);
      repeat (3) tick();
      dn[1] = 1'b1;
      tick();
      dn[1] = 1'b0;
      chk("gap_latv", 32'(lv[1]), 32'd1);
      chk("gap_lat",  ll[1],      32'd7);
      $display("gap txn %0d: latency %0d", t, ll[1]);
      if (t < 3) begin
        lows = 0;
        while (st[1] == 1'b0 && lows < 10) begin
          lows++;
          tick();
        end
        chk("gap_low_cycles", 32'(lows), 32'd3);
      end else begin
        chk("gap_finish", 32'(fn[1]), 32'd1);
        chk("gap_done",   32'(td[1]), 32'd4);
        chk("gap_maxlat", mx[1],      32'd7);
      end
    end

    // Timeout on instance 2: done never arrives
    go[2] = 1'b1;
    tick();
    go[2] = 1'b0;
    rdy[2] = 1'b1;
    tick();
    rdy[2] = 1'b0;
    repeat (8) tick();
    chk("to_pre_error",  32'(er[2]), 32'd0);
    chk("to_pre_finish", 32'(fn[2]), 32'd0);
    chk("to_pre_busy",   32'(bz[2]), 32'd1);
    tick();
    chk("to_error",  32'(er[2]),  32'd1);
    chk("to_finish", 32'(fn[2]),  32'd1);
    chk("to_start",  32'(st[2]),  32'd0);
    chk("to_busy",   32'(bz[2]),  32'd0);
    chk("to_done",   32'(td[2]),  32'd0);
    chk("to_issued", 32'(iss[2]), 32'd1);
    $display("timeout txn: error=%0d finish=%0d", er[2], fn[2]);
    tick();
    chk("to_finish_held", 32'(fn[2]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
